// File: rtl/systolic_feed_sequencer.sv
// Feeds an N x N output-stationary systolic array: clears it, copies A/B out of
// storage into local buffers, then streams them onto the array edges with diagonal skew.
module systolic_feed_sequencer #(
    parameter int N       = 4,
    parameter int A_WIDTH = 16,
    parameter int B_WIDTH = 8,
    parameter int AW      = $clog2(N*N)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   array_clear,
    output logic                   a_rd_en,
    output logic [AW-1:0]          a_rd_addr,
    input  logic [A_WIDTH-1:0]     a_rd_data,
    output logic                   b_rd_en,
    output logic [AW-1:0]          b_rd_addr,
    input  logic [B_WIDTH-1:0]     b_rd_data,
    output logic [N*A_WIDTH-1:0]   a_row_out,
    output logic [N*B_WIDTH-1:0]   b_col_out,
    output logic                   feed_valid
);

    localparam int LOAD_LEN = N*N;
    localparam int FEED_LEN = 3*N-2;
    localparam int CW       = $clog2(N*N+1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_LOAD_WAIT,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic               cap_valid_reg;
    logic [AW-1:0]      cap_idx_reg;

    logic [A_WIDTH-1:0] abuf [N*N];
    logic [B_WIDTH-1:0] bbuf [N*N];

    logic [CW-1:0]        feed_t;
    logic [N*A_WIDTH-1:0] a_skew;
    logic [N*B_WIDTH-1:0] b_skew;

    // Read data lags the strobe by one cycle, so the capture address is a
    // delayed copy of the read address we issued.
    always_ff @(posedge clk) begin
        if (cap_valid_reg) begin
            abuf[cap_idx_reg] <= a_rd_data;
            bbuf[cap_idx_reg] <= b_rd_data;
        end
    end

    // Step index of the FEED cycle whose edge values are being registered now.
    always_comb begin
        feed_t = '0;
        if (state_reg == S_FEED)
            feed_t = cnt_reg + CW'(1);
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_edge
            logic [CW-1:0] off;
            logic          hit;
            logic [AW-1:0] a_idx;
            logic [AW-1:0] b_idx;

            assign off   = feed_t - CW'(gi);
            assign hit   = (feed_t >= CW'(gi)) && (off < CW'(N));
            assign a_idx = AW'(gi*N) + AW'(off);
            assign b_idx = AW'(off * CW'(N)) + AW'(gi);

            assign a_skew[gi*A_WIDTH +: A_WIDTH] = hit ? abuf[a_idx] : '0;
            assign b_skew[gi*B_WIDTH +: B_WIDTH] = hit ? bbuf[b_idx] : '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            cap_valid_reg <= 1'b0;
            cap_idx_reg   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            array_clear   <= 1'b0;
            a_rd_en       <= 1'b0;
            b_rd_en       <= 1'b0;
            a_rd_addr     <= '0;
            b_rd_addr     <= '0;
            a_row_out     <= '0;
            b_col_out     <= '0;
            feed_valid    <= 1'b0;
        end else begin
            cap_valid_reg <= a_rd_en;
            cap_idx_reg   <= a_rd_addr;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg   <= S_CLEAR;
                        busy        <= 1'b1;
                        array_clear <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_reg   <= S_LOAD;
                    array_clear <= 1'b0;
                    a_rd_en     <= 1'b1;
                    b_rd_en     <= 1'b1;
                    a_rd_addr   <= '0;
                    b_rd_addr   <= '0;
                    cnt_reg     <= '0;
                end
                S_LOAD: begin
                    if (cnt_reg == CW'(LOAD_LEN-1)) begin
                        state_reg <= S_LOAD_WAIT;
                        a_rd_en   <= 1'b0;
                        b_rd_en   <= 1'b0;
                        a_rd_addr <= '0;
                        b_rd_addr <= '0;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                        a_rd_addr <= AW'(cnt_reg + CW'(1));
                        b_rd_addr <= AW'(cnt_reg + CW'(1));
                    end
                end
                S_LOAD_WAIT: begin
                    // Step 0 only touches element 0, which was captured long ago.
                    state_reg  <= S_FEED;
                    feed_valid <= 1'b1;
                    a_row_out  <= a_skew;
                    b_col_out  <= b_skew;
                    cnt_reg    <= '0;
                end
                S_FEED: begin
                    if (cnt_reg == CW'(FEED_LEN-1)) begin
                        state_reg  <= S_DRAIN;
                        feed_valid <= 1'b0;
                        a_row_out  <= '0;
                        b_col_out  <= '0;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg    <= cnt_reg + CW'(1);
                        a_row_out  <= a_skew;
                        b_col_out  <= b_skew;
                    end
                end
                S_DRAIN: begin
                    if (cnt_reg == CW'(N-1)) begin
                        state_reg <= S_DONE;
                        done      <= 1'b1;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg   <= cnt_reg + CW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feed_sequencer.sv
// Scoreboard bench for systolic_feed_sequencer: the driver queues the expected
// outputs of every cycle of each pass, the monitor compares them on the falling edge.
module tb_systolic_feed_sequencer;

    localparam int N   = 4;
    localparam int AW  = $clog2(N*N);
    localparam int AWD = 16;
    localparam int BWD = 8;

    // Pass timeline for N=4, relative to the edge that accepts start
    localparam int CLR_C      = 1;
    localparam int LOAD_FIRST = 2;
    localparam int LOAD_LAST  = 17;
    localparam int FEED_FIRST = 19;
    localparam int FEED_LAST  = 28;
    localparam int DONE_C     = 33;
    localparam int PASS_END   = 34;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               done;
    logic               array_clear;
    logic               a_rd_en;
    logic [AW-1:0]      a_rd_addr;
    logic [AWD-1:0]     a_rd_data;
    logic               b_rd_en;
    logic [AW-1:0]      b_rd_addr;
    logic [BWD-1:0]     b_rd_data;
    logic [N*AWD-1:0]   a_row_out;
    logic [N*BWD-1:0]   b_col_out;
    logic               feed_valid;

    systolic_feed_sequencer #(.N(N), .A_WIDTH(AWD), .B_WIDTH(BWD)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .array_clear (array_clear),
        .a_rd_en     (a_rd_en),
        .a_rd_addr   (a_rd_addr),
        .a_rd_data   (a_rd_data),
        .b_rd_en     (b_rd_en),
        .b_rd_addr   (b_rd_addr),
        .b_rd_data   (b_rd_data),
        .a_row_out   (a_row_out),
        .b_col_out   (b_col_out),
        .feed_valid  (feed_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AWD-1:0] a_mem [N*N];
    logic [BWD-1:0] b_mem [N*N];

    initial begin
        a_rd_data = '0;
        b_rd_data = '0;
    end

    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    typedef struct {
        int               tag;
        int               rel;
        logic             busy;
        logic             done;
        logic             clr;
        logic             a_en;
        logic             b_en;
        logic             fv;
        logic [AW-1:0]    a_addr;
        logic [AW-1:0]    b_addr;
        logic [N*AWD-1:0] a_row;
        logic [N*BWD-1:0] b_col;
    } exp_t;

    exp_t sbq[$];
    int   vectors     = 0;
    int   miscompares = 0;

    function automatic exp_t make_exp(int tag, int rel);
        exp_t e;
        int   t;
        e.tag    = tag;
        e.rel    = rel;
        e.busy   = (rel >= 1) && (rel <= DONE_C);
        e.done   = (rel == DONE_C);
        e.clr    = (rel == CLR_C);
        e.a_en   = (rel >= LOAD_FIRST) && (rel <= LOAD_LAST);
        e.b_en   = e.a_en;
        e.fv     = (rel >= FEED_FIRST) && (rel <= FEED_LAST);
        e.a_addr = e.a_en ? AW'(rel - LOAD_FIRST) : '0;
        e.b_addr = e.a_addr;
        e.a_row  = '0;
        e.b_col  = '0;
        if (e.fv) begin
            t = rel - FEED_FIRST;
            for (int i = 0; i < N; i++) begin
                if (t - i >= 0 && t - i < N) begin
                    e.a_row[i*AWD +: AWD] = a_mem[i*N + (t - i)];
                    e.b_col[i*BWD +: BWD] = b_mem[(t - i)*N + i];
                end
            end
        end
        return e;
    endfunction

    // Monitor: compare every queued vector whose cycle has come up
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].tag <= cyc) begin
                e = sbq.pop_front();
                vectors++;
                if (e.tag < cyc) begin
                    miscompares++;
                    $display("FAIL missed_vector rel=%0d tag=%0d now=%0d", e.rel, e.tag, cyc);
                end else if (busy !== e.busy || done !== e.done || array_clear !== e.clr ||
                             a_rd_en !== e.a_en || b_rd_en !== e.b_en || feed_valid !== e.fv ||
                             a_rd_addr !== e.a_addr || b_rd_addr !== e.b_addr ||
                             a_row_out !== e.a_row || b_col_out !== e.b_col) begin
                    miscompares++;
                    $display("FAIL pass_cycle rel=%0d: got busy=%b done=%b clr=%b en=%b%b fv=%b addr=%h/%h a=%h b=%h; expected busy=%b done=%b clr=%b en=%b%b fv=%b addr=%h/%h a=%h b=%h",
                             e.rel, busy, done, array_clear, a_rd_en, b_rd_en, feed_valid,
                             a_rd_addr, b_rd_addr, a_row_out, b_col_out,
                             e.busy, e.done, e.clr, e.a_en, e.b_en, e.fv,
                             e.a_addr, e.b_addr, e.a_row, e.b_col);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) tick();
    endtask

    task automatic load_pat(int kind);
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                case (kind)
                    0: begin
                        a_mem[i*N+j] = AWD'(16'h0100*i + j);
                        b_mem[i*N+j] = BWD'(8'h10*i + j);
                    end
                    1: begin
                        a_mem[i*N+j] = 16'hFFFF;
                        b_mem[i*N+j] = 8'hFF;
                    end
                    2: begin
                        a_mem[i*N+j] = AWD'(16'hA000 + 16'h0111*(i*N+j));
                        b_mem[i*N+j] = BWD'(8'h80 + 3*(i*N+j));
                    end
                    default: begin
                        a_mem[i*N+j] = AWD'(16'hC3C3 - 16'h0101*(i*N+j));
                        b_mem[i*N+j] = BWD'(8'hF0 - (i*N+j));
                    end
                endcase
            end
        end
    endtask

    task automatic issue_start(input string name, output int s);
        start = 1'b1;
        s = cyc + 1;
        for (int r = 1; r <= PASS_END; r++)
            sbq.push_back(make_exp(s + r - 1, r));
        $display("pass %s: start accepted at cycle %0d", name, s);
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 200 && sbq.size() > 0; k++) tick();
        if (sbq.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d expected=0", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        int s;
        int s2;
        rst   = 1'b1;
        start = 1'b0;
        load_pat(0);
        tick();
        tick();

        // Reset state, then idle with start low
        sbq.push_back(make_exp(cyc, -1));
        sbq.push_back(make_exp(cyc + 1, -1));
        tick();
        rst = 1'b0;
        sbq.push_back(make_exp(cyc + 1, -1));
        sbq.push_back(make_exp(cyc + 2, -1));
        drain();

        issue_start("skew", s);
        drain();

        load_pat(1);
        issue_start("full_width", s);
        drain();

        load_pat(2);
        issue_start("start_while_busy", s);
        wait_until(s + 4);
        pulse_start();
        wait_until(s + 19);
        pulse_start();
        wait_until(s + 32);
        pulse_start();
        drain();

        load_pat(3);
        issue_start("reset_mid_feed", s);
        wait_until(s + 21);
        rst = 1'b1;
        while (sbq.size() > 0 && sbq[$].tag >= s + 22) void'(sbq.pop_back());
        for (int r = 0; r < 3; r++) sbq.push_back(make_exp(s + 22 + r, -1));
        tick();
        rst = 1'b0;
        drain();

        load_pat(0);
        issue_start("after_reset", s);
        drain();

        load_pat(2);
        issue_start("back_to_back_1", s);
        wait_until(s + 32);
        load_pat(3);
        wait_until(s + 33);
        issue_start("back_to_back_2", s2);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
